// File: rtl/rv_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_alu_ctrl_if
// Decode-side bus of the ALU issue controller: request handshake, response
// handshake and the flush strobe.
//
//   req_valid / req_ready   request handshake (decode -> controller)
//   req_op                  4-bit opcode
//   req_op1 / req_op2       32-bit operands
//   req_tag                 TAG_W-bit tag, echoed on the response
//   flush                   abort the operation in flight
//   rsp_valid / rsp_ready   response handshake (controller -> decode)
//   rsp_data                32-bit result
//   rsp_tag                 tag of the completed operation
//   rsp_err                 illegal opcode or timeout
//
// master: decode stage side; slave: rv_alu_ctrl side.
// ---------------------------------------------------------------------------
interface rv_alu_ctrl_if #(
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_op1, req_op2, req_tag, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, req_tag, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/rv_alu_ctrl.sv
// ---------------------------------------------------------------------------
// rv_alu_ctrl
// Issue/sequencing controller between the decode stage and the shared ALU.
// Accepts one operation per request handshake, registers the operands,
// pulses the ALU for one cycle with decoded command strobes, waits for the
// ALU write-enable on multi-cycle ops (shift, multiply), builds SLT/SLTU/SEQ
// from the ALU's registered compare flags and returns the result on the
// response handshake. A timeout and a flush/drain path keep it from hanging.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   dec_bus (slave)       request/response handshakes and flush
//   alu_valid_o           single-cycle ALU start strobe
//   alu_cmd_o[11:0]       {signed, addsub, mul, div, div_mod, cmp,
//                          negate_op2, and, xor, shift, shift_right, mul_high}
//   alu_op1_o/alu_op2_o   registered operands, held until the next accept
//   alu_result_i          ALU result
//   alu_we_i              ALU result valid
//   alu_cmp_eq_i/ug_i/sg_i  ALU registered compare flags
// ---------------------------------------------------------------------------
module rv_alu_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  rv_alu_ctrl_if.slave dec_bus,
  output logic         alu_valid_o,
  output logic [11:0]  alu_cmd_o,
  output logic [31:0]  alu_op1_o,
  output logic [31:0]  alu_op2_o,
  input  logic [31:0]  alu_result_i,
  input  logic         alu_we_i,
  input  logic         alu_cmp_eq_i,
  input  logic         alu_cmp_ug_i,
  input  logic         alu_cmp_sg_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_SEQ  = 4'd12;

  localparam int CMD_SIGNED   = 11;
  localparam int CMD_ADDSUB   = 10;
  localparam int CMD_MUL      = 9;
  localparam int CMD_CMP      = 6;
  localparam int CMD_NEG      = 5;
  localparam int CMD_AND      = 4;
  localparam int CMD_XOR      = 3;
  localparam int CMD_SHIFT    = 2;
  localparam int CMD_SHIFT_R  = 1;
  localparam int CMD_MUL_HIGH = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_CMPRD,
    S_RESP,
    S_DRAIN
  } state_e;

  // Opcode to ALU command strobes. OR is issued as AND+XOR; the ALU
  // OR-combines the two terms, and (a&b)|(a^b) == a|b.
  function automatic logic [11:0] decode_cmd(input logic [3:0] op);
    logic [11:0] c;
    c = '0;
    case (op)
      OP_ADD:  c[CMD_ADDSUB] = 1'b1;
      OP_SUB:  begin c[CMD_ADDSUB] = 1'b1; c[CMD_NEG] = 1'b1; end
      OP_AND:  c[CMD_AND] = 1'b1;
      OP_XOR:  c[CMD_XOR] = 1'b1;
      OP_OR:   begin c[CMD_AND] = 1'b1; c[CMD_XOR] = 1'b1; end
      OP_SLL:  c[CMD_SHIFT] = 1'b1;
      OP_SRL:  begin c[CMD_SHIFT] = 1'b1; c[CMD_SHIFT_R] = 1'b1; end
      OP_SRA:  begin
        c[CMD_SHIFT]   = 1'b1;
        c[CMD_SHIFT_R] = 1'b1;
        c[CMD_SIGNED]  = 1'b1;
      end
      OP_MUL:  c[CMD_MUL] = 1'b1;
      OP_MULH: begin c[CMD_MUL] = 1'b1; c[CMD_MUL_HIGH] = 1'b1; end
      OP_SLT, OP_SLTU, OP_SEQ: begin c[CMD_CMP] = 1'b1; c[CMD_NEG] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_multi;
  logic is_cmp;
  logic timed_out;
  logic cmp_bit;

  assign is_multi  = (op_q >= OP_SLL) && (op_q <= OP_MULH);
  assign is_cmp    = (op_q >= OP_SLT) && (op_q <= OP_SEQ);
  assign timed_out = (cnt_q == CNT_LAST);

  // The flags are registered inside the ALU, so they are only meaningful
  // in CMPRD, one cycle after the compare was issued.
  always_comb begin
    cmp_bit = 1'b0;
    case (op_q)
      OP_SLT:  cmp_bit = ~alu_cmp_sg_i & ~alu_cmp_eq_i;
      OP_SLTU: cmp_bit = ~alu_cmp_ug_i & ~alu_cmp_eq_i;
      default: cmp_bit = alu_cmp_eq_i;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Flush always wins over normal progress; a flushed
  // multi-cycle op still has an ALU result coming, so it is drained rather
  // than abandoned, otherwise a late alu_we_i could land on the next op.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (dec_bus.req_valid && !dec_bus.flush) begin
          op_d  = dec_bus.req_op;
          op1_d = dec_bus.req_op1;
          op2_d = dec_bus.req_op2;
          tag_d = dec_bus.req_tag;
          if (dec_bus.req_op > OP_SEQ) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        cnt_d = '0;
        if (dec_bus.flush) begin
          state_d = (is_multi && !alu_we_i) ? S_DRAIN : S_IDLE;
        end else if (is_cmp) begin
          state_d = S_CMPRD;
        end else if (alu_we_i) begin
          data_d  = alu_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (dec_bus.flush) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (alu_we_i || timed_out) ? S_IDLE : S_DRAIN;
        end else if (alu_we_i) begin
          data_d  = alu_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CMPRD: begin
        if (dec_bus.flush) begin
          state_d = S_IDLE;
        end else begin
          data_d  = {31'd0, cmp_bit};
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (dec_bus.flush || dec_bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (alu_we_i || timed_out) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dec_bus.req_ready = (state_q == S_IDLE);
  assign dec_bus.rsp_valid = (state_q == S_RESP);
  assign dec_bus.rsp_data  = data_q;
  assign dec_bus.rsp_tag   = tag_q;
  assign dec_bus.rsp_err   = err_q;

  assign alu_valid_o = (state_q == S_EXEC);
  assign alu_cmd_o   = alu_valid_o ? decode_cmd(op_q) : 12'd0;
  assign alu_op1_o   = op1_q;
  assign alu_op2_o   = op2_q;

endmodule

// File: tb/tb_rv_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_alu_ctrl
// Self-checking bench for rv_alu_ctrl. A small ALU model answers the
// controller (combinational result for single-cycle ops, programmable delay
// for shift/multiply, registered compare flags). Expected responses are
// computed from the request opcode and operands, pushed to a scoreboard
// queue at accept time and popped when the response shows up.
// ---------------------------------------------------------------------------
module tb_rv_alu_ctrl;

  localparam int TAG_W = 4;
  localparam int TMO   = 8;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [11:0] alu_cmd;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        alu_we;
  logic        cmp_eq = 1'b0, cmp_ug = 1'b0, cmp_sg = 1'b0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ALU model state
  int          mc_delay = 0;
  logic        pend_act = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] comb_res;
  logic [31:0] nb;
  logic [63:0] prod;
  logic        single;
  int          alu_pulses = 0;
  int          rsp_cycles = 0;

  rv_alu_ctrl_if #(.TAG_W(TAG_W)) dec_bus ();

  rv_alu_ctrl #(.TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dec_bus      (dec_bus),
    .alu_valid_o  (alu_valid),
    .alu_cmd_o    (alu_cmd),
    .alu_op1_o    (alu_op1),
    .alu_op2_o    (alu_op2),
    .alu_result_i (alu_result),
    .alu_we_i     (alu_we),
    .alu_cmp_eq_i (cmp_eq),
    .alu_cmp_ug_i (cmp_ug),
    .alu_cmp_sg_i (cmp_sg)
  );

  always #5 clk = ~clk;

  // ALU model: interprets the command strobes
  assign nb     = alu_cmd[5] ? (~alu_op2 + 32'd1) : alu_op2;
  assign prod   = {32'd0, alu_op1} * {32'd0, alu_op2};
  assign single = alu_valid & ~alu_cmd[2] & ~alu_cmd[9] & ~alu_cmd[6];
  assign alu_we = single | (pend_act && pend_cnt == 1);
  assign alu_result = single ? comb_res : pend_res;

  always_comb begin
    comb_res = 32'd0;
    if (alu_cmd[10])
      comb_res = alu_op1 + nb;
    else if (alu_cmd[4] | alu_cmd[3])
      comb_res = (alu_cmd[4] ? (alu_op1 & alu_op2) : 32'd0) |
                 (alu_cmd[3] ? (alu_op1 ^ alu_op2) : 32'd0);
    else if (alu_cmd[2] && !alu_cmd[1])
      comb_res = alu_op1 << alu_op2[4:0];
    else if (alu_cmd[2] && alu_cmd[11])
      comb_res = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
    else if (alu_cmd[2])
      comb_res = alu_op1 >> alu_op2[4:0];
    else if (alu_cmd[9])
      comb_res = alu_cmd[0] ? prod[63:32] : prod[31:0];
  end

  always @(posedge clk) begin
    if (alu_valid) alu_pulses <= alu_pulses + 1;
    if (dec_bus.rsp_valid) rsp_cycles <= rsp_cycles + 1;
    if (alu_valid && alu_cmd[6]) begin
      cmp_eq <= (alu_op1 == alu_op2);
      cmp_ug <= (alu_op1 > alu_op2);
      cmp_sg <= ($signed(alu_op1) > $signed(alu_op2));
    end
    if (alu_valid && (alu_cmd[2] || alu_cmd[9]) && mc_delay > 0) begin
      pend_act <= 1'b1;
      pend_cnt <= mc_delay;
      pend_res <= comb_res;
    end else if (pend_act) begin
      if (pend_cnt == 1) pend_act <= 1'b0;
      else pend_cnt <= pend_cnt - 1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: sim time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour of each opcode
  function automatic logic [31:0] expData(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a ^ b;
      4'd4:  return a | b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return p[31:0];
      4'd9:  return p[63:32];
      4'd10: return {31'd0, $signed(a) < $signed(b)};
      4'd11: return {31'd0, a < b};
      4'd12: return {31'd0, a == b};
      default: return 32'd0;
    endcase
  endfunction

  // Drive a request, wait (bounded) for the handshake, push the expectation
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] tag,
                               output bit ok);
    exp_t e;
    ok = 1'b0;
    dec_bus.req_valid = 1'b1;
    dec_bus.req_op    = op;
    dec_bus.req_op1   = a;
    dec_bus.req_op2   = b;
    dec_bus.req_tag   = tag;
    for (int i = 0; i < 20; i++) begin
      if (dec_bus.req_ready === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    dec_bus.req_valid = 1'b0;
    if (ok) begin
      e.data = expData(op, a, b);
      e.tag  = tag;
      e.err  = (op > 4'd12);
      sb.push_back(e);
    end
  endtask

  // Bounded wait for rsp_valid; lat counts clock edges after the accept edge
  task automatic waitRsp(input int limit, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat <= limit) begin
      if (dec_bus.rsp_valid === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
  endtask

  task automatic finishRsp();
    dec_bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    dec_bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dec_bus.req_valid = 1'b0; dec_bus.req_op = '0; dec_bus.req_op1 = '0;
    dec_bus.req_op2 = '0; dec_bus.req_tag = '0; dec_bus.flush = 1'b0;
    dec_bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dec_bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 1", dec_bus.req_ready);
    end
    checks++;
    if (dec_bus.rsp_valid !== 1'b0 || dec_bus.rsp_err !== 1'b0 || dec_bus.rsp_data !== 32'd0
        || dec_bus.rsp_tag !== '0) begin
      errors++; $display("[TB] FAIL reset_rsp: got v=%b e=%b d=%h t=%h want all 0",
                         dec_bus.rsp_valid, dec_bus.rsp_err, dec_bus.rsp_data, dec_bus.rsp_tag);
    end
    checks++;
    if (alu_valid !== 1'b0 || alu_cmd !== 12'd0) begin
      errors++; $display("[TB] FAIL reset_alu: got v=%b cmd=%h want 0 000", alu_valid, alu_cmd);
    end
    checks++;
    if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_ops: got %h %h want 0 0", alu_op1, alu_op2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    bit ok; int p0; exp_t e;
    p0 = alu_pulses;
    applyStimulus(4'd1, 32'd5, 32'd7, 4'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL sub_accept: got no handshake want accept"); return; end
    checks++;
    if (alu_valid !== 1'b1 || alu_cmd !== 12'h420 || dec_bus.rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL sub_exec: got v=%b cmd=%h rsp=%b want 1 420 0",
                         alu_valid, alu_cmd, dec_bus.rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_valid !== 1'b0 || dec_bus.rsp_valid !== 1'b1 || alu_pulses - p0 != 1) begin
      errors++; $display("[TB] FAIL sub_timing: got alu_v=%b rsp_v=%b pulses=%0d want 0 1 1",
                         alu_valid, dec_bus.rsp_valid, alu_pulses - p0);
    end
    e = sb.pop_front();
    checks++;
    if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
      errors++; $display("[TB] FAIL sub_rsp: got %h/%h/%b want %h/%h/%b", dec_bus.rsp_data,
                         dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
    end
    finishRsp();
  endtask

  task automatic test_or();
    bit ok; exp_t e;
    applyStimulus(4'd4, 32'hF0F0_0000, 32'h0000_0F0F, 4'd5, ok);
    checks++;
    if (!ok || alu_cmd !== 12'h018) begin
      errors++; $display("[TB] FAIL or_cmd: got ok=%b cmd=%h want 1 018", ok, alu_cmd);
      return;
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (dec_bus.rsp_valid !== 1'b1 || dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag
        || dec_bus.rsp_err !== e.err) begin
      errors++; $display("[TB] FAIL or_rsp: got v=%b %h/%h/%b want 1 %h/%h/%b", dec_bus.rsp_valid,
                         dec_bus.rsp_data, dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
    end
    finishRsp();
  endtask

  task automatic test_compare();
    logic [3:0]  ops[4] = '{4'd10, 4'd11, 4'd12, 4'd10};
    logic [31:0] av[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd1};
    logic [31:0] bv[4]  = '{32'd1, 32'd1, 32'd9, 32'hFFFF_FFFF};
    bit ok, got; int lat; exp_t e;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], av[i], bv[i], 4'(i + 8), ok);
      checks++;
      if (!ok || alu_cmd !== 12'h060) begin
        errors++; $display("[TB] FAIL cmp_cmd[%0d]: got ok=%b cmd=%h want 1 060", i, ok, alu_cmd);
        continue;
      end
      waitRsp(10, lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 2) begin
        errors++; $display("[TB] FAIL cmp_lat[%0d]: got got=%b lat=%0d want 1 2", i, got, lat);
      end
      checks++;
      if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
        errors++; $display("[TB] FAIL cmp_rsp[%0d]: got %h/%h/%b want %h/%h/%b", i, dec_bus.rsp_data,
                           dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
      end
      finishRsp();
    end
  endtask

  task automatic test_multicycle();
    logic [3:0]  ops[5]  = '{4'd8, 4'd5, 4'd6, 4'd7, 4'd9};
    logic [31:0] av[5]   = '{32'd6, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] bv[5]   = '{32'd7, 32'd4, 32'd31, 32'd4, 32'h0003_0000};
    logic [11:0] cmds[5] = '{12'h200, 12'h004, 12'h006, 12'h806, 12'h201};
    int          dly[5]  = '{3, 1, 2, 1, 2};
    bit ok, got; int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      mc_delay = dly[i];
      applyStimulus(ops[i], av[i], bv[i], 4'(i + 1), ok);
      checks++;
      if (!ok || alu_cmd !== cmds[i]) begin
        errors++; $display("[TB] FAIL mc_cmd[%0d]: got ok=%b cmd=%h want 1 %h", i, ok, alu_cmd, cmds[i]);
        continue;
      end
      waitRsp(20, lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat != dly[i] + 1) begin
        errors++; $display("[TB] FAIL mc_lat[%0d]: got got=%b lat=%0d want 1 %0d", i, got, lat, dly[i] + 1);
      end
      checks++;
      if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
        errors++; $display("[TB] FAIL mc_rsp[%0d]: got %h/%h/%b want %h/%h/%b", i, dec_bus.rsp_data,
                           dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
      end
      // first op: stall the response for four cycles
      if (i == 0) begin
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          checks++;
          if (dec_bus.rsp_valid !== 1'b1 || dec_bus.rsp_data !== e.data || dec_bus.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mc_stall[%0d]: got v=%b d=%h rdy=%b want 1 %h 0", k,
                               dec_bus.rsp_valid, dec_bus.rsp_data, dec_bus.req_ready, e.data);
          end
        end
        dec_bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (dec_bus.req_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL mc_hs_ready: got %b want 0", dec_bus.req_ready);
        end
        @(posedge clk); #1;
        dec_bus.rsp_ready = 1'b0;
        checks++;
        if (dec_bus.req_ready !== 1'b1 || dec_bus.rsp_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL mc_after_hs: got rdy=%b v=%b want 1 0",
                             dec_bus.req_ready, dec_bus.rsp_valid);
        end
      end else begin
        finishRsp();
      end
    end
    mc_delay = 0;
  endtask

  task automatic test_timeout();
    bit ok, got; int lat, p0; exp_t e;
    mc_delay = 0;
    applyStimulus(4'd8, 32'd3, 32'd4, 4'd2, ok);
    waitRsp(40, lat, got);
    checks++;
    if (!ok || !got || lat != TMO + 1) begin
      errors++; $display("[TB] FAIL tmo_lat: got ok=%b got=%b lat=%0d want 1 1 %0d", ok, got, lat, TMO + 1);
    end
    if (ok) begin
      e = sb.pop_front();
      e.data = 32'd0;
      e.err  = 1'b1;
      checks++;
      if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
        errors++; $display("[TB] FAIL tmo_rsp: got %h/%h/%b want %h/%h/%b", dec_bus.rsp_data,
                           dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
      end
    end
    finishRsp();
    // illegal opcode
    p0 = alu_pulses;
    applyStimulus(4'd14, 32'd11, 32'd12, 4'd7, ok);
    waitRsp(5, lat, got);
    checks++;
    if (!ok || !got || lat != 0) begin
      errors++; $display("[TB] FAIL ill_lat: got ok=%b got=%b lat=%0d want 1 1 0", ok, got, lat);
    end
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
        errors++; $display("[TB] FAIL ill_rsp: got %h/%h/%b want %h/%h/%b", dec_bus.rsp_data,
                           dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
      end
    end
    finishRsp();
    checks++;
    if (alu_pulses != p0) begin
      errors++; $display("[TB] FAIL ill_pulse: got %0d alu pulses want 0", alu_pulses - p0);
    end
  endtask

  task automatic test_flush();
    bit ok; int r0, p0, n; exp_t e;
    // flush in WAIT, ALU answers two cycles later
    r0 = rsp_cycles;
    mc_delay = 3;
    applyStimulus(4'd8, 32'd2, 32'd3, 4'd1, ok);
    if (ok) e = sb.pop_front();
    @(posedge clk); #1;
    dec_bus.flush = 1'b1;
    @(posedge clk); #1;
    dec_bus.flush = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dec_bus.req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_busy: got rdy=%b want 0", dec_bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (!ok || dec_bus.req_ready !== 1'b1 || rsp_cycles != r0) begin
      errors++; $display("[TB] FAIL drain_idle: got ok=%b rdy=%b rsp=%0d want 1 1 0", ok,
                         dec_bus.req_ready, rsp_cycles - r0);
    end
    mc_delay = 0;
    // flush in RESP drops the response
    applyStimulus(4'd0, 32'd1, 32'd2, 4'd4, ok);
    if (ok) e = sb.pop_front();
    @(posedge clk); #1;
    dec_bus.flush = 1'b1;
    @(posedge clk); #1;
    dec_bus.flush = 1'b0;
    checks++;
    if (!ok || dec_bus.rsp_valid !== 1'b0 || dec_bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_resp: got ok=%b v=%b rdy=%b want 1 0 1", ok,
                         dec_bus.rsp_valid, dec_bus.req_ready);
    end
    // flush in IDLE blocks a simultaneous request
    p0 = alu_pulses;
    dec_bus.req_valid = 1'b1; dec_bus.req_op = 4'd0; dec_bus.flush = 1'b1;
    @(posedge clk); #1;
    dec_bus.req_valid = 1'b0; dec_bus.flush = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_pulses != p0 || dec_bus.req_ready !== 1'b1 || dec_bus.rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_idle: got pulses=%0d rdy=%b v=%b want 0 1 0",
                         alu_pulses - p0, dec_bus.req_ready, dec_bus.rsp_valid);
    end
    // flush in EXEC of a multi-cycle op drains until timeout
    r0 = rsp_cycles;
    applyStimulus(4'd8, 32'd5, 32'd5, 4'd6, ok);
    if (ok) e = sb.pop_front();
    dec_bus.flush = 1'b1;
    @(posedge clk); #1;
    dec_bus.flush = 1'b0;
    n = 0;
    while (dec_bus.req_ready !== 1'b1 && n < 3 * TMO) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!ok || n != TMO || rsp_cycles != r0) begin
      errors++; $display("[TB] FAIL flush_exec: got ok=%b drain=%0d rsp=%0d want 1 %0d 0", ok, n,
                         rsp_cycles - r0, TMO);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, got; int lat; exp_t e;
    logic [3:0] op;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(0, 4));
      applyStimulus(op, $urandom, $urandom, 4'(i), ok);
      waitRsp(5, lat, got);
      checks++;
      if (!ok || !got || lat != 1) begin
        errors++; $display("[TB] FAIL b2b_lat[%0d]: got ok=%b got=%b lat=%0d want 1 1 1", i, ok, got, lat);
        continue;
      end
      e = sb.pop_front();
      checks++;
      if (dec_bus.rsp_data !== e.data || dec_bus.rsp_tag !== e.tag || dec_bus.rsp_err !== e.err) begin
        errors++; $display("[TB] FAIL b2b_rsp[%0d] op=%0d: got %h/%h/%b want %h/%h/%b", i, op,
                           dec_bus.rsp_data, dec_bus.rsp_tag, dec_bus.rsp_err, e.data, e.tag, e.err);
      end
      finishRsp();
    end
  endtask

  task automatic test_async_reset();
    bit ok; exp_t e;
    applyStimulus(4'd2, 32'hFF, 32'h0F, 4'd6, ok);
    if (ok) e = sb.pop_front();
    @(posedge clk); #1;
    checks++;
    if (!ok || dec_bus.rsp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL areset_pre: got ok=%b v=%b want 1 1", ok, dec_bus.rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dec_bus.rsp_valid !== 1'b0 || dec_bus.req_ready !== 1'b1 || dec_bus.rsp_data !== 32'd0) begin
      errors++; $display("[TB] FAIL areset: got v=%b rdy=%b d=%h want 0 1 0", dec_bus.rsp_valid,
                         dec_bus.req_ready, dec_bus.rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_or();
    test_compare();
    test_multicycle();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_alu_ctrl.md
Name: rv_alu_ctrl

Overview:
Issue/sequencing controller between the decode stage and the shared ALU. It accepts one operation per valid/ready handshake and registers the operands. It decodes a 4-bit opcode into ALU command strobes, drives a single-cycle ALU valid pulse and waits for the ALU write-enable on multi-cycle ops (shift, multiply). It synthesises SLT/SLTU/SEQ from the registered compare flags and returns the result on a valid/ready response port, with a timeout and a flush/drain path.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before an error response (must be >= 2)
TAG_W, 4, width of the request/response tag

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  controller can accept a request
req_op_i  in  4  opcode
req_op1_i  in  32  operand 1
req_op2_i  in  32  operand 2
req_tag_i  in  TAG_W  tag, returned unchanged
flush_i  in  1  abort current operation
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  32  result
rsp_tag_o  out  TAG_W  tag of the op
rsp_err_o  out  1  illegal opcode or timeout
alu_valid_o  out  1  ALU valid strobe
alu_cmd_o  out  12  {signed, addsub, mul, div, div_mod, cmp, negate_op2, and, xor, shift, shift_right, mul_high}
alu_op1_o  out  32  registered operand 1
alu_op2_o  out  32  registered operand 2
alu_result_i  in  32  ALU result
alu_we_i  in  1  ALU result valid
alu_cmp_eq_i, alu_cmp_ug_i, alu_cmp_sg_i  in  1 each  registered compare flags

Behaviour:
- Reset: async assert on rst_n_i low. State IDLE. All outputs 0 except req_ready_o=1. Registers cleared.
- Opcode decode (commands driven only while alu_valid_o=1, otherwise 0):
  - 0 ADD: addsub
  - 1 SUB: addsub+negate_op2
  - 2 AND: and
  - 3 XOR: xor
  - 4 OR: and+xor (the ALU OR-combines the two terms, giving a|b)
  - 5 SLL: shift
  - 6 SRL: shift+shift_right
  - 7 SRA: shift+shift_right+signed
  - 8 MUL: mul
  - 9 MULH: mul+mul_high
  - 10 SLT, 11 SLTU, 12 SEQ: cmp+negate_op2
  - 13-15: illegal
- States:
  - IDLE: req_ready_o=1. On req_valid_i, latch op/operands/tag and go to EXEC. Illegal opcode goes to RESP with data=0, err=1, and the ALU is never pulsed.
  - EXEC: exactly one cycle. alu_valid_o=1, commands driven.
    - Compare ops go to CMPRD.
    - Otherwise, if alu_we_i is high the same cycle (ADD/SUB/logic), capture alu_result_i and go to RESP.
    - Otherwise go to WAIT and clear the timeout counter.
  - WAIT: alu_valid_o=0. On alu_we_i, capture the result and go to RESP. The counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 without alu_we_i, go to RESP with data=0, err=1.
  - CMPRD: one cycle. Flags are valid now.
    - SLT: data = ~sg & ~eq.
    - SLTU: data = ~ug & ~eq.
    - SEQ: data = eq.
    - Result is zero-extended to 32 bits. Go to RESP.
  - RESP: rsp_valid_o=1; data/tag/err held stable. On rsp_ready_i go to IDLE. req_ready_o stays 0 until IDLE (no accept in the same cycle as response completion).
  - DRAIN: entered on flush_i while in WAIT. No response is produced. Leave to IDLE on alu_we_i or timeout.
- Flush: flush_i in EXEC, CMPRD or RESP goes to IDLE next cycle and the response is dropped. Exception: in EXEC with a multi-cycle op and no same-cycle alu_we_i, go to DRAIN. Flush in IDLE takes priority over a simultaneous request, which is not accepted.
- Latency, request accepted at cycle T:
  - ADD/logic: rsp_valid_o at T+2.
  - Compare: rsp_valid_o at T+3.
  - Multi-cycle: rsp_valid_o one cycle after alu_we_i.
- alu_op1_o and alu_op2_o hold their values from accept until the next accept.

Test Plan:
- SUB op1=5, op2=7, tag=3, accepted cycle T -> alu_valid_o pulse at T+1 only; rsp_valid_o at T+2 with data=0xFFFFFFFE, tag=3, err=0.
- OR 0xF0F0_0000 | 0x0000_0F0F -> rsp_data_o=0xF0F0_0F0F; alu_cmd_o shows and=1, xor=1.
- SLT op1=0xFFFFFFFF, op2=1 -> data=1. SLTU with the same operands -> data=0. SEQ 9,9 -> data=1. Each rsp_valid_o at T+3.
- MUL with alu_we_i returned 3 cycles after EXEC, rsp_ready_i held low 4 cycles -> response and data stable throughout; req_ready_o=0 until the cycle after the handshake.
- WAIT with alu_we_i never asserted, TIMEOUT_CYCLES=8 -> rsp_err_o=1, data=0. Opcode 14 -> err=1, alu_valid_o never asserted.
- flush_i during WAIT, then alu_we_i 2 cycles later -> no response; return to IDLE. Async reset mid-RESP -> rsp_valid_o=0 immediately, req_ready_o=1.
